// File: rtl/onehot_to_bin_if.sv
// Stream bundle for the one-hot to binary encoder: input stream, output stream
// and the malformed-input counter readout.
interface onehot_to_bin_if #(
    parameter int ONE_HOT_W = 16,
    parameter int BIN_W     = 4,
    parameter int ERR_CNT_W = 8
);
    logic [ONE_HOT_W-1:0] one_hot;
    logic                 in_valid;
    logic                 in_ready;
    logic [BIN_W-1:0]     bin;
    logic                 zero_err;
    logic                 multi_err;
    logic                 out_valid;
    logic                 out_ready;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output one_hot, in_valid, out_ready,
        input  in_ready, bin, zero_err, multi_err, out_valid, err_cnt
    );

    modport slave (
        input  one_hot, in_valid, out_ready,
        output in_ready, bin, zero_err, multi_err, out_valid, err_cnt
    );
endinterface

// File: rtl/onehot_to_bin.sv
// Registered one-hot to binary encoder with a single output stage, malformed
// input flags and a saturating malformed-input counter.
module onehot_to_bin #(
    parameter int ONE_HOT_W = 16,
    parameter int BIN_W     = 4,
    parameter int ERR_CNT_W = 8
) (
    input logic           clk,
    input logic           reset_n,
    onehot_to_bin_if.slave bus
);
    logic [ONE_HOT_W-1:0] lowest;
    logic [BIN_W-1:0]     enc_bin;
    logic                 enc_zero;
    logic                 enc_multi;
    logic                 in_fire;
    logic                 out_fire;

    logic [BIN_W-1:0]     bin_q;
    logic                 zero_q;
    logic                 multi_q;
    logic                 valid_q;
    logic [ERR_CNT_W-1:0] cnt_q;

    // Isolate the lowest set bit so multi-hot inputs encode to that index.
    always_comb begin
        lowest    = bus.one_hot & (~bus.one_hot + 1'b1);
        enc_bin   = '0;
        for (int i = 0; i < ONE_HOT_W; i++) begin
            if (lowest[i]) enc_bin = enc_bin | BIN_W'(i);
        end
        enc_zero  = ~|bus.one_hot;
        enc_multi = |(bus.one_hot & (bus.one_hot - 1'b1));
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bin_q   <= '0;
            zero_q  <= 1'b0;
            multi_q <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (in_fire) begin
                bin_q   <= enc_bin;
                zero_q  <= enc_zero;
                multi_q <= enc_multi;
                valid_q <= 1'b1;
                if ((enc_zero || enc_multi) && (cnt_q != {ERR_CNT_W{1'b1}}))
                    cnt_q <= cnt_q + 1'b1;
            end else if (out_fire) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.bin       = bin_q;
    assign bus.zero_err  = zero_q;
    assign bus.multi_err = multi_q;
    assign bus.out_valid = valid_q;
    assign bus.err_cnt   = cnt_q;
endmodule

// File: tb/tb_onehot_to_bin.sv
// Self-checking bench for onehot_to_bin: directed scenarios plus randomized
// traffic against a behavioural model of the encoder and its output stage.
module tb_onehot_to_bin;
    localparam int OW = 16;
    localparam int BW = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    onehot_to_bin_if #(.ONE_HOT_W(OW), .BIN_W(BW), .ERR_CNT_W(CW)) bus ();

    onehot_to_bin #(.ONE_HOT_W(OW), .BIN_W(BW), .ERR_CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Behavioural model state
    logic          m_valid;
    logic [BW-1:0] m_bin;
    logic          m_zero;
    logic          m_multi;
    int            m_cnt;

    function automatic int lowest_index(input logic [OW-1:0] v);
        int idx = 0;
        while (idx < OW && ((v >> idx) & 16'd1) == 16'd0) idx++;
        return (idx == OW) ? 0 : idx;
    endfunction

    task automatic drive(input logic [OW-1:0] v, input logic vld, input logic ordy);
        bus.one_hot   = v;
        bus.in_valid  = vld;
        bus.out_ready = ordy;
        #1;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        int  ones;
        logic accept;
        ones   = $countones(bus.one_hot);
        accept = bus.in_valid && (!m_valid || bus.out_ready);
        if (!reset_n) begin
            m_valid = 0; m_bin = 0; m_zero = 0; m_multi = 0; m_cnt = 0;
        end else if (accept) begin
            m_valid = 1;
            m_bin   = BW'(lowest_index(bus.one_hot));
            m_zero  = (ones == 0);
            m_multi = (ones >= 2);
            if (ones != 1 && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive('0, 1'b0, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        drive('0, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.bin !== '0 || bus.zero_err !== 1'b0 ||
            bus.multi_err !== 1'b0 || bus.err_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b bin=%0d z=%0b m=%0b cnt=%0d expected all 0",
                     bus.out_valid, bus.bin, bus.zero_err, bus.multi_err, bus.err_cnt);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_sweep();
        for (int k = 0; k < OW; k++) begin
            drive(16'd1 << k, 1'b1, 1'b1);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL sweep_in_ready k=%0d: got %0b expected 1", k, bus.in_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.bin !== BW'(k) || bus.zero_err !== 1'b0 ||
                bus.multi_err !== 1'b0 || bus.err_cnt !== '0) begin
                errors++;
                $display("FAIL sweep k=%0d: valid=%0b bin=%0d z=%0b m=%0b cnt=%0d expected 1 %0d 0 0 0",
                         k, bus.out_valid, bus.bin, bus.zero_err, bus.multi_err, bus.err_cnt, k);
            end
        end
    endtask

    task automatic test_malformed();
        logic [OW-1:0] vecs [3]  = '{16'h0000, 16'h0104, 16'h8000};
        int            ebin [3]  = '{0, 2, 15};
        logic          ez   [3]  = '{1'b1, 1'b0, 1'b0};
        logic          em   [3]  = '{1'b0, 1'b1, 1'b0};
        int            ecnt [3]  = '{1, 2, 2};
        for (int i = 0; i < 3; i++) begin
            drive(vecs[i], 1'b1, 1'b1);
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.bin !== BW'(ebin[i]) || bus.zero_err !== ez[i] ||
                bus.multi_err !== em[i] || bus.err_cnt !== CW'(ecnt[i])) begin
                errors++;
                $display("FAIL malformed %h: valid=%0b bin=%0d z=%0b m=%0b cnt=%0d expected 1 %0d %0b %0b %0d",
                         vecs[i], bus.out_valid, bus.bin, bus.zero_err, bus.multi_err, bus.err_cnt,
                         ebin[i], ez[i], em[i], ecnt[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        drive(16'h0020, 1'b1, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(16'h0400, 1'b1, 1'b0);
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready c=%0d: got %0b expected 0", c, bus.in_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.bin !== 4'd5) begin
                errors++;
                $display("FAIL bp_hold c=%0d: valid=%0b bin=%0d expected 1 5", c, bus.out_valid, bus.bin);
            end
        end
        drive(16'h0400, 1'b1, 1'b1);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %0b expected 1", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.bin !== 4'd10) begin
            errors++;
            $display("FAIL bp_release: valid=%0b bin=%0d expected 1 10", bus.out_valid, bus.bin);
        end
        drive('0, 1'b0, 1'b1);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: valid=%0b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [OW-1:0] v;
        logic          vld;
        logic          ordy;
        v = '0;
        vld = 1'b0;
        for (int n = 0; n < 400; n++) begin
            // Upstream holds its vector until accepted.
            if (!(vld && !bus.in_ready)) begin
                case ($urandom_range(0, 3))
                    0, 1: v = 16'd1 << $urandom_range(0, OW - 1);
                    2:    v = '0;
                    default: v = OW'($urandom);
                endcase
                vld = ($urandom_range(0, 3) != 0);
            end
            ordy = ($urandom_range(0, 2) != 0);
            drive(v, vld, ordy);
            checks++;
            if (bus.in_ready !== (!m_valid || ordy)) begin
                errors++;
                $display("FAIL rand_in_ready n=%0d: got %0b expected %0b", n, bus.in_ready, !m_valid || ordy);
            end
            tick();
            checks++;
            if (bus.out_valid !== m_valid || bus.err_cnt !== CW'(m_cnt) ||
                (m_valid && (bus.bin !== m_bin || bus.zero_err !== m_zero || bus.multi_err !== m_multi))) begin
                errors++;
                $display("FAIL rand n=%0d: valid=%0b bin=%0d z=%0b m=%0b cnt=%0d expected %0b %0d %0b %0b %0d",
                         n, bus.out_valid, bus.bin, bus.zero_err, bus.multi_err, bus.err_cnt,
                         m_valid, m_bin, m_zero, m_multi, m_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(16'hFFFF, 1'b1, 1'b1);
            tick();
            checks++;
            if (bus.bin !== '0 || bus.multi_err !== 1'b1 || bus.zero_err !== 1'b0 ||
                bus.err_cnt !== CW'((i + 1 > 255) ? 255 : i + 1)) begin
                errors++;
                $display("FAIL saturation i=%0d: bin=%0d m=%0b z=%0b cnt=%0d expected 0 1 0 %0d",
                         i, bus.bin, bus.multi_err, bus.zero_err, bus.err_cnt,
                         (i + 1 > 255) ? 255 : i + 1);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(16'h0000, 1'b1, 1'b1);
            tick();
        end
        drive(16'h0080, 1'b1, 1'b1);
        tick();
        drive(16'h0001, 1'b1, 1'b0);
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.bin !== 4'd7 || bus.err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL midreset_setup: valid=%0b bin=%0d cnt=%0d expected 1 7 3",
                     bus.out_valid, bus.bin, bus.err_cnt);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        drive('0, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.bin !== '0 || bus.err_cnt !== '0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset: valid=%0b bin=%0d cnt=%0d rdy=%0b expected 0 0 0 1",
                     bus.out_valid, bus.bin, bus.err_cnt, bus.in_ready);
        end
    endtask

    initial begin
        m_valid = 0; m_bin = 0; m_zero = 0; m_multi = 0; m_cnt = 0;
        drive('0, 1'b0, 1'b0);
        test_reset();
        test_sweep();
        test_malformed();
        test_backpressure();
        test_random();
        test_saturation();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
